// File: rtl/branch_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_exec_if
// Purpose  : Handshake and data bundle between the branch execution stage,
//            its upstream issue logic and the downstream writeback/fetch side.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_exec_if #(
    parameter int P_ADDR_W = 32
);
    logic                iFLUSH;
    logic                iPREV_VALID;
    logic                oPREV_LOCK;
    logic [P_ADDR_W-1:0] iDATA_1;
    logic [P_ADDR_W-1:0] iPC;
    logic [4:0]          iFLAG;
    logic [3:0]          iCC;
    logic [4:0]          iCMD;
    logic                iPREDICT_TAKEN;
    logic [P_ADDR_W-1:0] iPREDICT_ADDR;
    logic                iWAKEUP;
    logic                oNEXT_VALID;
    logic                iNEXT_LOCK;
    logic [P_ADDR_W-1:0] oBRANCH_ADDR;
    logic [P_ADDR_W-1:0] oREDIRECT_ADDR;
    logic                oJUMP_VALID;
    logic                oNOT_JUMP_VALID;
    logic                oIB_VALID;
    logic                oIDTS_VALID;
    logic                oHALT_VALID;
    logic                oMISPREDICT;

    modport master (
        output iFLUSH, iPREV_VALID, iDATA_1, iPC, iFLAG, iCC, iCMD,
               iPREDICT_TAKEN, iPREDICT_ADDR, iWAKEUP, iNEXT_LOCK,
        input  oPREV_LOCK, oNEXT_VALID, oBRANCH_ADDR, oREDIRECT_ADDR,
               oJUMP_VALID, oNOT_JUMP_VALID, oIB_VALID, oIDTS_VALID,
               oHALT_VALID, oMISPREDICT
    );

    modport slave (
        input  iFLUSH, iPREV_VALID, iDATA_1, iPC, iFLAG, iCC, iCMD,
               iPREDICT_TAKEN, iPREDICT_ADDR, iWAKEUP, iNEXT_LOCK,
        output oPREV_LOCK, oNEXT_VALID, oBRANCH_ADDR, oREDIRECT_ADDR,
               oJUMP_VALID, oNOT_JUMP_VALID, oIB_VALID, oIDTS_VALID,
               oHALT_VALID, oMISPREDICT
    );
endinterface
`default_nettype wire

// File: rtl/branch_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : branch_exec_stage
// Purpose  : Registered branch resolve/mispredict stage with flush window and
//            HALT/wakeup control. Optional BRANCH_EXEC_STAT_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_exec_stage #(
    parameter int P_ADDR_W       = 32,
    parameter int P_PC_INC       = 4,
    parameter int P_FLUSH_CYCLES = 2
) (
    input  wire logic     iCLOCK,
    input  wire logic     iRESET,
    branch_exec_if.slave  bus
`ifdef BRANCH_EXEC_STAT_EN
    ,
    output logic [31:0]   oSTAT_BRANCH,
    output logic [31:0]   oSTAT_MISS
`endif
);

    localparam logic [4:0] EXE_BRANCH_BUR  = 5'h00;
    localparam logic [4:0] EXE_BRANCH_BR   = 5'h01;
    localparam logic [4:0] EXE_BRANCH_B    = 5'h02;
    localparam logic [4:0] EXE_BRANCH_INTB = 5'h03;
    localparam logic [4:0] EXE_BRANCH_IDTS = 5'h04;
    localparam logic [4:0] EXE_BRANCH_HALT = 5'h05;

    localparam int FLAGS_ZF = 0;
    localparam int FLAGS_PF = 1;
    localparam int FLAGS_CF = 2;
    localparam int FLAGS_OF = 3;
    localparam int FLAGS_SF = 4;

    localparam int CNT_W = ($clog2(P_FLUSH_CYCLES + 1) < 1) ? 1 : $clog2(P_FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(P_FLUSH_CYCLES);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    flush_cnt;
    logic                accept;
    logic                run_take;
    logic                taken;
    logic                signed_lt;
    logic                jump_class;
    logic                is_intb;
    logic                is_idts;
    logic                is_halt;
    logic                mispredict;
    logic [P_ADDR_W-1:0] target;
    logic [P_ADDR_W-1:0] fall_thru;
    logic [P_ADDR_W-1:0] redirect;

    assign bus.oPREV_LOCK = (bus.oNEXT_VALID && bus.iNEXT_LOCK) || (state == ST_HALT);
    assign accept         = bus.iPREV_VALID && !bus.oPREV_LOCK;
    // Only commands taken in RUN produce a result; FLUSH swallows them.
    assign run_take       = accept && (state == ST_RUN);

    assign is_intb = (bus.iCMD == EXE_BRANCH_INTB);
    assign is_idts = (bus.iCMD == EXE_BRANCH_IDTS);
    assign is_halt = (bus.iCMD == EXE_BRANCH_HALT);

    always_comb begin
        signed_lt = bus.iFLAG[FLAGS_SF] ^ bus.iFLAG[FLAGS_OF];
        case (bus.iCC)
            4'd0:    taken = 1'b1;
            4'd1:    taken = bus.iFLAG[FLAGS_ZF];
            4'd2:    taken = !bus.iFLAG[FLAGS_ZF];
            4'd3:    taken = bus.iFLAG[FLAGS_SF];
            4'd4:    taken = !bus.iFLAG[FLAGS_SF];
            4'd5:    taken = !bus.iFLAG[FLAGS_PF];
            4'd6:    taken = bus.iFLAG[FLAGS_PF];
            4'd7:    taken = bus.iFLAG[FLAGS_OF];
            4'd8:    taken = bus.iFLAG[FLAGS_CF];
            4'd9:    taken = !bus.iFLAG[FLAGS_CF];
            4'd10:   taken = bus.iFLAG[FLAGS_CF] && !bus.iFLAG[FLAGS_ZF];
            4'd11:   taken = !bus.iFLAG[FLAGS_CF] || bus.iFLAG[FLAGS_ZF];
            4'd12:   taken = !signed_lt;
            4'd13:   taken = signed_lt;
            4'd14:   taken = !(signed_lt || bus.iFLAG[FLAGS_ZF]);
            4'd15:   taken = signed_lt || bus.iFLAG[FLAGS_ZF];
            default: taken = 1'b1;
        endcase
    end

    always_comb begin
        fall_thru  = bus.iPC + P_ADDR_W'(P_PC_INC);
        jump_class = 1'b0;
        target     = '0;
        case (bus.iCMD)
            EXE_BRANCH_BUR,
            EXE_BRANCH_BR: begin
                jump_class = 1'b1;
                target     = bus.iPC + bus.iDATA_1;
            end
            EXE_BRANCH_B: begin
                jump_class = 1'b1;
                target     = bus.iDATA_1;
            end
            EXE_BRANCH_IDTS: target = fall_thru;
            default:         target = '0;
        endcase

        // Interrupt/IDT entries are never predicted, so they always restart fetch.
        if (jump_class) begin
            mispredict = (taken != bus.iPREDICT_TAKEN) ||
                         (taken && (target != bus.iPREDICT_ADDR));
            redirect   = taken ? target : fall_thru;
        end else begin
            mispredict = is_intb || is_idts;
            redirect   = target;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state               <= ST_RUN;
            flush_cnt           <= '0;
            bus.oNEXT_VALID     <= 1'b0;
            bus.oBRANCH_ADDR    <= '0;
            bus.oREDIRECT_ADDR  <= '0;
            bus.oJUMP_VALID     <= 1'b0;
            bus.oNOT_JUMP_VALID <= 1'b0;
            bus.oIB_VALID       <= 1'b0;
            bus.oIDTS_VALID     <= 1'b0;
            bus.oHALT_VALID     <= 1'b0;
            bus.oMISPREDICT     <= 1'b0;
        end else if (bus.iFLUSH) begin
            state           <= ST_RUN;
            flush_cnt       <= '0;
            bus.oNEXT_VALID <= 1'b0;
        end else begin
            if (run_take) begin
                bus.oNEXT_VALID     <= 1'b1;
                bus.oBRANCH_ADDR    <= target;
                bus.oREDIRECT_ADDR  <= redirect;
                bus.oJUMP_VALID     <= taken && !(is_intb || is_idts);
                bus.oNOT_JUMP_VALID <= !taken && !(is_intb || is_idts);
                bus.oIB_VALID       <= is_intb;
                bus.oIDTS_VALID     <= is_idts;
                bus.oHALT_VALID     <= is_halt;
                bus.oMISPREDICT     <= mispredict;
            end else if (!bus.iNEXT_LOCK) begin
                bus.oNEXT_VALID <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (run_take) begin
                        if (is_halt) begin
                            state <= ST_HALT;
                        end else if (mispredict && (P_FLUSH_CYCLES > 0)) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= CNT_LOAD;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt - CNT_W'(1);
                    if (flush_cnt <= CNT_W'(1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (bus.iWAKEUP) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef BRANCH_EXEC_STAT_EN
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            oSTAT_BRANCH <= '0;
            oSTAT_MISS   <= '0;
        end else if (!bus.iFLUSH && run_take && jump_class) begin
            oSTAT_BRANCH <= oSTAT_BRANCH + 32'd1;
            if (mispredict) begin
                oSTAT_MISS <= oSTAT_MISS + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_exec_stage
// Purpose  : Self-checking bench: vector table, handshake corner sequences and
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_exec_stage;

    localparam int AW = 32;
    localparam int FC = 2;

    localparam logic [4:0] C_BUR = 5'h00, C_BR = 5'h01, C_B = 5'h02;
    localparam logic [4:0] C_INTB = 5'h03, C_IDTS = 5'h04, C_HALT = 5'h05;
    localparam logic [3:0] CC_AL = 4'd0, CC_EQ = 4'd1, CC_NEQ = 4'd2, CC_EN = 4'd5;
    localparam logic [3:0] CC_UU = 4'd9, CC_UO = 4'd10, CC_SU = 4'd13, CC_SO = 4'd14, CC_SEU = 4'd15;

    typedef struct {
        logic        j, nj, ib, idts, hl;
        logic [31:0] ba, ra;
        logic        rchk;
        logic        mis;
    } res_t;

    typedef struct {
        logic [4:0]  cmd;
        logic [3:0]  cc;
        logic [4:0]  fl;
        logic [31:0] pc, d1;
        logic        pt;
        logic [31:0] pa;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    branch_exec_if #(.P_ADDR_W(AW)) bus ();

`ifdef BRANCH_EXEC_STAT_EN
    logic [31:0] stat_branch, stat_miss;
`endif

    branch_exec_stage #(
        .P_ADDR_W       (AW),
        .P_PC_INC       (4),
        .P_FLUSH_CYCLES (FC)
    ) dut (
        .iCLOCK (clk),
        .iRESET (rst),
        .bus    (bus)
`ifdef BRANCH_EXEC_STAT_EN
        ,
        .oSTAT_BRANCH (stat_branch),
        .oSTAT_MISS   (stat_miss)
`endif
    );

    // Reference: condition codes evaluated as flag relations, targets by plain arithmetic.
    function automatic res_t ref_result(input logic [4:0] cmd, input logic [3:0] cc, input logic [4:0] fl,
                                        input logic [31:0] pc, input logic [31:0] d1,
                                        input logic pt, input logic [31:0] pa);
        res_t r;
        bit zf = fl[0], pf = fl[1], cf = fl[2], ov = fl[3], sf = fl[4];
        bit lt = sf ^ ov;
        bit tk;
        logic [31:0] fall = pc + 32'd4;
        case (cc)
            4'd0: tk = 1;        4'd1: tk = zf;         4'd2: tk = !zf;        4'd3: tk = sf;
            4'd4: tk = !sf;      4'd5: tk = !pf;        4'd6: tk = pf;         4'd7: tk = ov;
            4'd8: tk = cf;       4'd9: tk = !cf;        4'd10: tk = cf && !zf; 4'd11: tk = !cf || zf;
            4'd12: tk = !lt;     4'd13: tk = lt;        4'd14: tk = !(lt || zf);
            default: tk = lt || zf;
        endcase
        r = '{default: '0};
        r.ib   = (cmd == C_INTB);
        r.idts = (cmd == C_IDTS);
        r.hl   = (cmd == C_HALT);
        r.j    = tk && !(r.ib || r.idts);
        r.nj   = !tk && !(r.ib || r.idts);
        if (cmd == C_BUR || cmd == C_BR) r.ba = pc + d1;
        else if (cmd == C_B)             r.ba = d1;
        else if (cmd == C_IDTS)          r.ba = fall;
        else                             r.ba = 32'd0;
        if (cmd == C_BUR || cmd == C_BR || cmd == C_B) begin
            r.rchk = 1;
            r.ra   = tk ? r.ba : fall;
            r.mis  = (tk != pt) || (tk && r.ba != pa);
        end else if (r.ib || r.idts) begin
            r.rchk = 1;
            r.ra   = r.ba;
            r.mis  = 1;
        end
        return r;
    endfunction

    function automatic bit res_match(input res_t e);
        return bus.oJUMP_VALID === e.j && bus.oNOT_JUMP_VALID === e.nj && bus.oIB_VALID === e.ib &&
               bus.oIDTS_VALID === e.idts && bus.oHALT_VALID === e.hl && bus.oBRANCH_ADDR === e.ba &&
               (!e.rchk || bus.oREDIRECT_ADDR === e.ra) && bus.oMISPREDICT === e.mis;
    endfunction

    function automatic string dut_str();
        return $sformatf("v=%0b j=%0b nj=%0b ib=%0b idts=%0b hl=%0b ba=%h ra=%h mis=%0b lock=%0b",
                         bus.oNEXT_VALID, bus.oJUMP_VALID, bus.oNOT_JUMP_VALID, bus.oIB_VALID,
                         bus.oIDTS_VALID, bus.oHALT_VALID, bus.oBRANCH_ADDR, bus.oREDIRECT_ADDR,
                         bus.oMISPREDICT, bus.oPREV_LOCK);
    endfunction

    function automatic string exp_str(input logic v, input res_t e);
        return $sformatf("v=%0b j=%0b nj=%0b ib=%0b idts=%0b hl=%0b ba=%h ra=%h(chk=%0b) mis=%0b",
                         v, e.j, e.nj, e.ib, e.idts, e.hl, e.ba, e.ra, e.rchk, e.mis);
    endfunction

    task automatic check(input string name, input bit ok, input string got, input string want);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s required %s", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [4:0] cmd, input logic [3:0] cc, input logic [4:0] fl,
                         input logic [31:0] pc, input logic [31:0] d1, input logic pt, input logic [31:0] pa);
        bus.iPREV_VALID    = pv;
        bus.iCMD           = cmd;
        bus.iCC            = cc;
        bus.iFLAG          = fl;
        bus.iPC            = pc;
        bus.iDATA_1        = d1;
        bus.iPREDICT_TAKEN = pt;
        bus.iPREDICT_ADDR  = pa;
    endtask

    task automatic flush_pulse();
        bus.iPREV_VALID = 1'b0;
        bus.iNEXT_LOCK  = 1'b0;
        bus.iWAKEUP     = 1'b0;
        bus.iFLUSH      = 1'b1;
        tick();
        bus.iFLUSH      = 1'b0;
    endtask

    function automatic vec_t mk(input logic [4:0] cmd, input logic [3:0] cc, input logic [4:0] fl,
                                input logic [31:0] pc, input logic [31:0] d1, input logic pt, input logic [31:0] pa,
                                input logic j, input logic nj, input logic ib, input logic idts, input logic hl,
                                input logic [31:0] ba, input logic [31:0] ra, input logic rchk, input logic mis);
        vec_t v;
        v.cmd = cmd; v.cc = cc; v.fl = fl; v.pc = pc; v.d1 = d1; v.pt = pt; v.pa = pa;
        v.exp = '{j, nj, ib, idts, hl, ba, ra, rchk, mis};
        return v;
    endfunction

    vec_t vecs[13];

    // Reference model state for randomized traffic
    logic m_valid;
    int   m_flush_left;
    bit   m_halted;
    res_t m_res;

    initial begin
        vecs[0]  = mk(C_BR,   CC_AL,  5'b00000, 32'h100,      32'h20,       1, 32'h120,  1,0,0,0,0, 32'h120,  32'h120,  1, 0);
        vecs[1]  = mk(C_B,    CC_EQ,  5'b00000, 32'h200,      32'h4000,     1, 32'h4000, 0,1,0,0,0, 32'h4000, 32'h204,  1, 1);
        vecs[2]  = mk(C_BUR,  CC_AL,  5'b00000, 32'hFFFFFFF0, 32'h20,       1, 32'h10,   1,0,0,0,0, 32'h10,   32'h10,   1, 0);
        vecs[3]  = mk(C_BR,   CC_NEQ, 5'b00000, 32'h300,      32'h10,       0, 32'h0,    1,0,0,0,0, 32'h310,  32'h310,  1, 1);
        vecs[4]  = mk(C_BR,   CC_SU,  5'b10000, 32'h400,      32'h8,        1, 32'h500,  1,0,0,0,0, 32'h408,  32'h408,  1, 1);
        vecs[5]  = mk(C_B,    CC_UU,  5'b00100, 32'h10,       32'h80,       0, 32'h999,  0,1,0,0,0, 32'h80,   32'h14,   1, 0);
        vecs[6]  = mk(C_INTB, CC_AL,  5'b00000, 32'h50,       32'h1234,     0, 32'h0,    0,0,1,0,0, 32'h0,    32'h0,    1, 1);
        vecs[7]  = mk(C_IDTS, CC_AL,  5'b00000, 32'h60,       32'h0,        0, 32'h0,    0,0,0,1,0, 32'h64,   32'h64,   1, 1);
        vecs[8]  = mk(C_HALT, CC_AL,  5'b00000, 32'h70,       32'h0,        0, 32'h0,    1,0,0,0,1, 32'h0,    32'h0,    0, 0);
        vecs[9]  = mk(5'h1F,  CC_SO,  5'b00000, 32'h80,       32'h44,       0, 32'h0,    1,0,0,0,0, 32'h0,    32'h0,    0, 0);
        vecs[10] = mk(C_BR,   CC_UO,  5'b00100, 32'h700,      32'hFFFFFFFC, 1, 32'h6FC,  1,0,0,0,0, 32'h6FC,  32'h6FC,  1, 0);
        vecs[11] = mk(C_BR,   CC_SEU, 5'b11000, 32'h800,      32'h40,       0, 32'h0,    0,1,0,0,0, 32'h840,  32'h804,  1, 0);
        vecs[12] = mk(C_BUR,  CC_EN,  5'b00010, 32'h1000,     32'h10,       1, 32'h1010, 0,1,0,0,0, 32'h1010, 32'h1004, 1, 1);

        // Reset
        rst = 1'b1;
        bus.iFLUSH = 1'b0; bus.iNEXT_LOCK = 1'b0; bus.iWAKEUP = 1'b0;
        drive(0, 5'h0, 4'h0, 5'h0, 32'h0, 32'h0, 0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset", {bus.oNEXT_VALID, bus.oJUMP_VALID, bus.oNOT_JUMP_VALID, bus.oIB_VALID, bus.oIDTS_VALID,
                        bus.oHALT_VALID, bus.oMISPREDICT, bus.oPREV_LOCK} === 8'h00 &&
                       bus.oBRANCH_ADDR === 32'h0 && bus.oREDIRECT_ADDR === 32'h0,
              dut_str(), "all zero");

        // Vector table: one command each, then flush back to a clean RUN state
        for (int i = 0; i < 13; i++) begin
            drive(1, vecs[i].cmd, vecs[i].cc, vecs[i].fl, vecs[i].pc, vecs[i].d1, vecs[i].pt, vecs[i].pa);
            tick();
            check($sformatf("vec%0d", i), bus.oNEXT_VALID === 1'b1 && res_match(vecs[i].exp),
                  dut_str(), exp_str(1'b1, vecs[i].exp));
            flush_pulse();
        end

        // Mispredict opens a 2-input discard window
        drive(1, C_B, CC_EQ, 5'b0, 32'h200, 32'h4000, 1, 32'h4000);
        tick();
        check("flushwin_mis", bus.oNEXT_VALID === 1'b1 && bus.oMISPREDICT === 1'b1 && bus.oREDIRECT_ADDR === 32'h204,
              dut_str(), "v=1 mis=1 ra=00000204");
        drive(1, C_BR, CC_AL, 5'b0, 32'h100, 32'h20, 1, 32'h120);
        tick();
        check("flushwin_drop1", bus.oNEXT_VALID === 1'b0, dut_str(), "v=0");
        tick();
        check("flushwin_drop2", bus.oNEXT_VALID === 1'b0, dut_str(), "v=0");
        tick();
        check("flushwin_third", bus.oNEXT_VALID === 1'b1 && bus.oBRANCH_ADDR === 32'h120 && bus.oMISPREDICT === 1'b0,
              dut_str(), "v=1 ba=00000120 mis=0");
        flush_pulse();

        // Downstream stall holds result and locks upstream
        drive(1, C_BR, CC_AL, 5'b0, 32'h100, 32'h20, 1, 32'h120);
        tick();
        drive(1, C_BUR, CC_AL, 5'b0, 32'hFFFFFFF0, 32'h20, 1, 32'h10);
        bus.iNEXT_LOCK = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall_lock%0d", k), bus.oPREV_LOCK === 1'b1, dut_str(), "lock=1");
            tick();
            check($sformatf("stall_hold%0d", k), bus.oNEXT_VALID === 1'b1 && bus.oBRANCH_ADDR === 32'h120 &&
                  bus.oJUMP_VALID === 1'b1, dut_str(), "v=1 j=1 ba=00000120");
        end
        bus.iNEXT_LOCK = 1'b0;
        #1;
        check("stall_release_accept", bus.oPREV_LOCK === 1'b0, dut_str(), "lock=0");
        tick();
        check("stall_release_result", bus.oNEXT_VALID === 1'b1 && bus.oBRANCH_ADDR === 32'h10, dut_str(), "v=1 ba=00000010");
        flush_pulse();

        // HALT then wakeup
        drive(1, C_HALT, CC_AL, 5'b0, 32'h90, 32'h0, 0, 32'h0);
        tick();
        check("halt_result", bus.oNEXT_VALID === 1'b1 && bus.oHALT_VALID === 1'b1, dut_str(), "v=1 hl=1");
        drive(1, C_BR, CC_AL, 5'b0, 32'h100, 32'h20, 1, 32'h120);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("halt_lock%0d", k), bus.oPREV_LOCK === 1'b1, dut_str(), "lock=1");
            tick();
            check($sformatf("halt_novalid%0d", k), bus.oNEXT_VALID === 1'b0, dut_str(), "v=0");
        end
        bus.iWAKEUP = 1'b1;
        tick();
        bus.iWAKEUP = 1'b0;
        #1;
        check("wakeup_unlock", bus.oPREV_LOCK === 1'b0, dut_str(), "lock=0");
        tick();
        check("wakeup_result", bus.oNEXT_VALID === 1'b1 && bus.oBRANCH_ADDR === 32'h120 && bus.oHALT_VALID === 1'b0,
              dut_str(), "v=1 ba=00000120 hl=0");
        flush_pulse();

        // External flush in the middle of a flush window
        drive(1, C_B, CC_EQ, 5'b0, 32'h200, 32'h4000, 1, 32'h4000);
        tick();
        drive(1, C_BR, CC_AL, 5'b0, 32'h300, 32'h30, 1, 32'h330);
        bus.iFLUSH = 1'b1;
        tick();
        bus.iFLUSH = 1'b0;
        check("xflush_clear", bus.oNEXT_VALID === 1'b0 && bus.oPREV_LOCK === 1'b0, dut_str(), "v=0 lock=0");
        tick();
        check("xflush_run", bus.oNEXT_VALID === 1'b1 && bus.oBRANCH_ADDR === 32'h330, dut_str(), "v=1 ba=00000330");
        flush_pulse();

        // Randomized traffic against the reference model
        m_valid = 1'b0; m_flush_left = 0; m_halted = 0; m_res = '{default: '0};
        for (int c = 0; c < 600; c++) begin
            logic [4:0] cmd; logic [3:0] cc; logic [4:0] fl; logic [31:0] pc, d1, pa; logic pt, pv, nl, fx, wk;
            int   kk;
            res_t r0, r;
            bit   m_lock, acc;
            kk  = $urandom_range(0, 9);
            cmd = (kk < 6) ? 5'(kk) : ((kk == 6) ? 5'h1F : 5'(kk + 4));
            cc  = 4'($urandom);
            fl  = 5'($urandom);
            pc  = $urandom;
            d1  = $urandom;
            r0  = ref_result(cmd, cc, fl, pc, d1, 1'b0, 32'h0);
            pt  = ($urandom_range(0, 3) == 0) ? !r0.j : r0.j;
            pa  = ($urandom_range(0, 3) == 0) ? $urandom : r0.ba;
            pv  = ($urandom_range(0, 3) != 0);
            nl  = ($urandom_range(0, 3) == 0);
            fx  = ($urandom_range(0, 40) == 0);
            wk  = ($urandom_range(0, 5) == 0);
            drive(pv, cmd, cc, fl, pc, d1, pt, pa);
            bus.iNEXT_LOCK = nl; bus.iFLUSH = fx; bus.iWAKEUP = wk;
            #1;
            m_lock = (m_valid && nl) || m_halted;
            check($sformatf("rnd_lock%0d", c), bus.oPREV_LOCK === m_lock, dut_str(), $sformatf("lock=%0b", m_lock));
            acc = pv && !m_lock;
            if (fx) begin
                m_valid = 1'b0; m_flush_left = 0; m_halted = 0;
            end else if (acc && m_flush_left == 0) begin
                r       = ref_result(cmd, cc, fl, pc, d1, pt, pa);
                m_res   = r;
                m_valid = 1'b1;
                if (r.hl) m_halted = 1;
                else if (r.mis && FC > 0) m_flush_left = FC;
            end else begin
                if (!nl) m_valid = 1'b0;
                if (m_flush_left > 0) m_flush_left--;
                if (m_halted && wk) m_halted = 0;
            end
            tick();
            check($sformatf("rnd_out%0d", c), bus.oNEXT_VALID === m_valid && (!m_valid || res_match(m_res)),
                  dut_str(), exp_str(m_valid, m_res));
        end
        bus.iFLUSH = 1'b0; bus.iWAKEUP = 1'b0; bus.iPREV_VALID = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_exec_stage.md
Name: branch_exec_stage

Overview:
- Registered, parametrised branch execution stage for the execute pipeline.
- Resolves branch condition and target from flags, condition code and command.
- Compares the result with the fetch-side prediction and signals a redirect on mismatch.
- Adds valid/lock pipeline handshake, a post-redirect flush window and a HALT/wakeup state machine in front of the writeback/fetch-redirect logic.

Parameters:
P_ADDR_W, 32, width of PC, operand and all address outputs
P_PC_INC, 4, fall-through increment added to PC
P_FLUSH_CYCLES, 2, cycles of input discard after a redirect (0 = none); counter width clog2(P_FLUSH_CYCLES+1), min 1

Ports:
iCLOCK  in  1  clock
iRESET  in  1  asynchronous active-high reset
iFLUSH  in  1  external pipeline flush (exception/interrupt)
iPREV_VALID  in  1  upstream command valid
oPREV_LOCK  out  1  upstream must hold
iDATA_1  in  P_ADDR_W  target operand / displacement
iPC  in  P_ADDR_W  PC of the branch instruction
iFLAG  in  5  flags (core.h FLAGS_* bit positions)
iCC  in  4  condition code (core.h CC_*)
iCMD  in  5  command (core.h EXE_BRANCH_*)
iPREDICT_TAKEN  in  1  fetch predicted taken
iPREDICT_ADDR  in  P_ADDR_W  fetch predicted target
iWAKEUP  in  1  leave HALT state
oNEXT_VALID  out  1  result valid
iNEXT_LOCK  in  1  downstream stall
oBRANCH_ADDR  out  P_ADDR_W  resolved target
oREDIRECT_ADDR  out  P_ADDR_W  fetch restart address
oJUMP_VALID / oNOT_JUMP_VALID / oIB_VALID / oIDTS_VALID / oHALT_VALID  out  1 each  registered command result
oMISPREDICT  out  1  fetch must restart at oREDIRECT_ADDR

Behaviour:
- Interface: one clock iCLOCK; iRESET is asynchronous and active-high. Reset: all outputs 0, state RUN, flush counter 0.
- Accept: iPREV_VALID && !oPREV_LOCK. oPREV_LOCK = (oNEXT_VALID && iNEXT_LOCK) || state==HALT.
- Latency 1: an accepted command sets oNEXT_VALID and updates all result outputs on the next edge.
- Stall: outputs hold while iNEXT_LOCK=1 and oNEXT_VALID=1. oNEXT_VALID drops when the result is consumed and nothing new is accepted.
- Condition check (taken): AL=1; EQ=ZF; NEQ=!ZF; MI=SF; PL=!SF; EN=!PF; ON=PF; OVF=OF; UEO=CF; UU=!CF; UO=CF&!ZF; UEU=!CF|ZF; SEO=!(SF^OF); SU=SF^OF; SO=!((SF^OF)|ZF); SEU=(SF^OF)|ZF; undefined CC=1.
- Target (all arithmetic mod 2^P_ADDR_W, carry discarded): BUR,BR=iPC+iDATA_1; B=iDATA_1; INTB=0; IDTS=iPC+P_PC_INC; other=0.
- Flags: JUMP=taken, NOT_JUMP=!taken, except both 0 for INTB/IDTS. IB, IDTS, HALT = command decode.
- Jump-class commands (BUR/BR/B):
  - mispredict = (taken != iPREDICT_TAKEN) || (taken && target != iPREDICT_ADDR).
  - oREDIRECT_ADDR = taken ? target : iPC+P_PC_INC.
- INTB/IDTS: always mispredict=1, oREDIRECT_ADDR=target. HALT and other commands: mispredict=0.
- FSM RUN/FLUSH/HALT:
  - RUN: accepted result with mispredict=1 and P_FLUSH_CYCLES>0 loads the counter and enters FLUSH.
  - FLUSH: inputs are accepted but discarded, with no oNEXT_VALID. Counter decrements per clock (stalled or not) and returns to RUN at 0.
  - A HALT command enters HALT after its result is registered (its result is output normally). HALT locks upstream; iWAKEUP -> RUN next cycle. iWAKEUP outside HALT is ignored.
- iFLUSH (priority below reset, above all else): oNEXT_VALID=0, counter=0, state RUN at the next edge. Any input presented in the same cycle is dropped.

Optional Feature:
- Macro BRANCH_EXEC_STAT_EN.
- Defined: adds outputs oSTAT_BRANCH (32) and oSTAT_MISS (32).
  - oSTAT_BRANCH increments on each registered jump-class command.
  - oSTAT_MISS increments on each of those with mispredict=1.
  - Both reset to 0, wrap at 2^32 and are unaffected by iFLUSH.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- BR, CC=AL, PC=0x100, DATA_1=0x20, predicted taken to 0x120 -> next cycle: VALID=1, JUMP=1, BRANCH_ADDR=0x120, MISPREDICT=0, state RUN.
- B, CC=EQ, ZF=0, DATA_1=0x4000, PC=0x200, predicted taken -> JUMP=0, NOT_JUMP=1, MISPREDICT=1, REDIRECT=0x204. The next 2 accepted inputs produce no oNEXT_VALID; the 3rd produces a result.
- BUR, PC=0xFFFFFFF0, DATA_1=0x20 -> BRANCH_ADDR=0x00000010 (wrap). Predicted 0x10 taken -> MISPREDICT=0.
- Result held with iNEXT_LOCK=1 for 3 cycles -> oPREV_LOCK=1 and outputs stable. Lock release -> a queued input is accepted the same cycle and its result appears the next cycle.
- HALT command -> HALT_VALID=1 one result, then oPREV_LOCK=1 indefinitely. iWAKEUP pulse -> oPREV_LOCK=0 the following cycle.
- iFLUSH asserted while oNEXT_VALID=1 in FLUSH state with counter=2 -> next cycle: VALID=0, state RUN, the next input is accepted and produces a result.
